// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: drains 128-bit FIFO words into a byte-wide UART.
// Define FIFO_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte per word.
module fifo_word_serializer #(
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [127:0] FIFO_DATA,
  input  logic         FIFO_EMPTY,
  output logic         FIFO_READ,
  output logic [7:0]   TX_DATA,
  output logic         TX_LOAD,
  input  logic         TX_BUSY,
  output logic         SER_BUSY,
  output logic         WORD_DONE
);

`ifdef FIFO_SERIALIZER_CHECKSUM_EN
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST = 5'd16;
`else
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = 4'd15;
`endif

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    LOAD,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic          armed;
  logic [127:0]  shreg;
  logic [CW-1:0] cnt;
  logic [7:0]    gcnt;
  logic [7:0]    last_byte;
  logic [7:0]    data_byte;
  logic [7:0]    cur_byte;
  logic          load;
`ifdef FIFO_SERIALIZER_CHECKSUM_EN
  logic [7:0]    xsum;
`endif

  assign data_byte = (MSB_FIRST != 0) ? shreg[127:120] : shreg[7:0];
`ifdef FIFO_SERIALIZER_CHECKSUM_EN
  assign cur_byte = (cnt == LAST) ? xsum : data_byte;
`else
  assign cur_byte = data_byte;
`endif

  // A byte is handed over in LOAD as soon as the UART is free
  assign load      = (state == LOAD) && !TX_BUSY;
  assign TX_LOAD   = load;
  assign TX_DATA   = load ? cur_byte : last_byte;
  assign WORD_DONE = load && (cnt == LAST);
  assign FIFO_READ = (state == READ);
  assign SER_BUSY  = (state != IDLE);

  // Word fetch, byte sequencing and inter-word gap
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      armed     <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      last_byte <= '0;
`ifdef FIFO_SERIALIZER_CHECKSUM_EN
      xsum      <= '0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && !FIFO_EMPTY) state <= READ;
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          shreg <= FIFO_DATA;
          cnt   <= '0;
`ifdef FIFO_SERIALIZER_CHECKSUM_EN
          xsum  <= '0;
`endif
          state <= LOAD;
        end
        LOAD: begin
          if (load) begin
            last_byte <= cur_byte;
`ifdef FIFO_SERIALIZER_CHECKSUM_EN
            if (cnt != LAST) xsum <= xsum ^ data_byte;
`endif
            if (cnt == LAST) begin
              gcnt  <= '0;
              state <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          shreg <= (MSB_FIRST != 0) ? (shreg << 8) : (shreg >> 8);
          cnt   <= cnt + CW'(1);
          state <= LOAD;
        end
        GAP: begin
          gcnt <= gcnt + 8'd1;
          if (gcnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb_fifo_word_serializer: two lanes (MSB-first/gap 0, LSB-first/gap 4)
// against a FIFO, UART and byte-stream reference model.
module tb_fifo_word_serializer;

`ifdef FIFO_SERIALIZER_CHECKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int GAP0 = 0;
  localparam int GAP1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] fdata [2];
  logic         fempty [2];
  logic         fread [2];
  logic [7:0]   tdata [2];
  logic         tload [2];
  logic         tbusy [2];
  logic         sbusy [2];
  logic         wdone [2];

  fifo_word_serializer #(.MSB_FIRST(1), .GAP_CYCLES(GAP0)) u0 (
    .CLK(clk), .RESET_N(rst_n),
    .FIFO_DATA(fdata[0]), .FIFO_EMPTY(fempty[0]), .FIFO_READ(fread[0]),
    .TX_DATA(tdata[0]), .TX_LOAD(tload[0]), .TX_BUSY(tbusy[0]),
    .SER_BUSY(sbusy[0]), .WORD_DONE(wdone[0])
  );

  fifo_word_serializer #(.MSB_FIRST(0), .GAP_CYCLES(GAP1)) u1 (
    .CLK(clk), .RESET_N(rst_n),
    .FIFO_DATA(fdata[1]), .FIFO_EMPTY(fempty[1]), .FIFO_READ(fread[1]),
    .TX_DATA(tdata[1]), .TX_LOAD(tload[1]), .TX_BUSY(tbusy[1]),
    .SER_BUSY(sbusy[1]), .WORD_DONE(wdone[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [127:0] fmem [2][8];
  int fhd [2];
  int ftl [2];
  int blen [2];
  int bcnt [2];
  logic [7:0] exq [2][64];
  int ehd [2];
  int etl [2];
  int exp_load [2];
  int busy_end [2];
  int next_read [2];
  int done_cyc [2];
  bit active [2];
  logic [7:0] held [2];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [127:0] w);
    fmem[i][ftl[i] % 8] = w;
    ftl[i]++;
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fempty[i] = (fhd[i] == ftl[i]);
      tbusy[i]  = (bcnt[i] > 0);
    end
  end

  // FIFO read port and UART busy model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (fread[i] && fhd[i] != ftl[i]) begin
        fdata[i] <= fmem[i][fhd[i] % 8];
        fhd[i]   <= fhd[i] + 1;
      end
      if (tload[i]) bcnt[i] <= blen[i];
      else if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      fhd[i] = 0; ftl[i] = 0; bcnt[i] = 0; blen[i] = 0;
      fdata[i] = '0; busy_end[i] = -100;
    end
  end

  // Reference byte stream and timing monitor
  initial begin
    logic [127:0] w;
    logic [7:0] b, x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          check("rst_out",
                {fread[i], tload[i], tdata[i], sbusy[i], wdone[i]}, '0);
          ehd[i] = etl[i];
          active[i] = 1'b0;
          done_cyc[i] = -100;
          next_read[i] = -1;
          held[i] = 8'h00;
        end else begin
          if (fread[i]) begin
            check("rd_nonempty", fempty[i], 1'b0);
            if (next_read[i] >= 0) check("rd_cyc", cyc, next_read[i]);
            check("rd_prev_done", etl[i] - ehd[i], 0);
            next_read[i] = -1;
            w = fmem[i][fhd[i] % 8];
            x = 8'h00;
            for (int k = 0; k < 16; k++) begin
              b = (i == 0) ? 8'(w >> (8 * (15 - k))) : 8'(w >> (8 * k));
              x ^= b;
              exq[i][etl[i] % 64] = b;
              etl[i]++;
            end
            if (NB == 17) begin
              exq[i][etl[i] % 64] = x;
              etl[i]++;
            end
            active[i] = 1'b1;
            exp_load[i] = (cyc + 2 > busy_end[i] + 1) ? cyc + 2
                                                       : busy_end[i] + 1;
          end
          if (tload[i]) begin
            check("busy_at_load", tbusy[i], 1'b0);
            if (ehd[i] == etl[i]) begin
              check("unexpected_load", 1'b1, 1'b0);
            end else begin
              check("load_cyc", cyc, exp_load[i]);
              check("tx_data", tdata[i], exq[i][ehd[i] % 64]);
              ehd[i]++;
              check("word_done", wdone[i], ehd[i] == etl[i]);
              busy_end[i] = cyc + blen[i];
              exp_load[i] = cyc + ((blen[i] + 1 > 2) ? blen[i] + 1 : 2);
              held[i] = tdata[i];
              if (ehd[i] == etl[i]) begin
                active[i] = 1'b0;
                done_cyc[i] = cyc;
                next_read[i] = (fhd[i] != ftl[i]) ? cyc + gap_of(i) + 2 : -1;
              end
            end
          end else begin
            check("wd_stray", wdone[i], 1'b0);
            check("tx_hold", tdata[i], held[i]);
            if (ehd[i] != etl[i] && cyc >= exp_load[i])
              check("load_due", tload[i], 1'b1);
          end
          check("ser_busy", sbusy[i],
                active[i] || (cyc <= done_cyc[i] + gap_of(i)));
        end
      end
    end
  end

  task automatic drain(input int lim);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      @(posedge clk);
      #2;
      ok = fempty[0] && fempty[1] && ehd[0] == etl[0] &&
           ehd[1] == etl[1] && !sbusy[0] && !sbusy[1];
    end
    check("drain_timeout", ok, 1'b1);
  endtask

  initial begin
    logic [127:0] wa;
    logic [127:0] wb;
    bit hit;
    wa = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wb = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    rst_n = 1'b0;
    blen[0] = 0;
    blen[1] = 10;
    push(0, wa); push(0, wb);
    push(1, wa); push(1, {$urandom, $urandom, $urandom, $urandom});
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    next_read[0] = cyc + 2;
    next_read[1] = cyc + 2;
    drain(600);

    for (int r = 0; r < 6; r++) begin
      blen[0] = $urandom_range(0, 3);
      blen[1] = $urandom_range(0, 12);
      for (int i = 0; i < 2; i++) begin
        int nw;
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++)
          push(i, {$urandom, $urandom, $urandom, $urandom});
        next_read[i] = cyc + 1;
      end
      drain(900);
    end

    blen[0] = 2;
    blen[1] = 3;
    push(0, wb);
    push(1, wa);
    next_read[0] = cyc + 1;
    next_read[1] = cyc + 1;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(posedge clk);
      #2;
      hit = (etl[0] - ehd[0] == NB - 6) && etl[0] != 0;
    end
    check("midword_reached", hit, 1'b1);
    rst_n = 1'b0;
    ftl[0] = fhd[0];
    ftl[1] = fhd[1];
    #1;
    for (int i = 0; i < 2; i++)
      check("midword_rst",
            {fread[i], tload[i], tdata[i], sbusy[i], wdone[i]}, '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("post_rst_idle", sbusy[i], 1'b0);
      check("post_rst_fifo", fhd[i], ftl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
